csr_io_unit: RTL

Memory-mapped CSR I/O responder for the 3-stage RISC-V core: the peripheral side of the CSRRW path. It captures writes to CSR 0xF00 (io0) into a display register that drives eight seven-segment digits. It also supplies synchronized, optionally debounced switch values for reads of CSR 0xF02 (io2). It sits beside the register file in the writeback stage, driven by `GPIO_we` and the rs1 data.

---
 rtl/csr_io_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/csr_io_unit.sv
// CSR I/O responder: io0 display register with seven-segment decode, and synchronized switch readback.
// Define GPIO_DEBOUNCE_EN to insert the switch debounce filter between the synchronizer and sw_stable.
module csr_io_unit #(
  parameter int NUM_SW    = 18,
  parameter int DB_CYCLES = 16'd50000,
  parameter int DB_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              GPIO_we,
  input  logic [31:0]       gpio_wdata,
  input  logic [NUM_SW-1:0] SW,
  output logic [31:0]       gpio_rdata,
  output logic [31:0]       io0_out,
  output logic              io0_valid,
  output logic              upd_pulse,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5,
  output logic [6:0]        HEX6,
  output logic [6:0]        HEX7
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  if (NUM_SW < 1 || NUM_SW > 32 || DB_CYCLES < 2 ||
      longint'(DB_CYCLES) >= (longint'(1) << DB_W)) begin : g_bad_cfg
    $error("csr_io_unit: illegal NUM_SW / DB_CYCLES / DB_W combination");
  end

  logic [NUM_SW-1:0] sync1;
  logic [NUM_SW-1:0] sync2;
  logic [NUM_SW-1:0] sw_stable;
  logic [6:0]        hex_q [8];

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io0_out   <= '0;
      io0_valid <= 1'b0;
      upd_pulse <= 1'b0;
    end else begin
      upd_pulse <= GPIO_we;
      if (GPIO_we) begin
        io0_out   <= gpio_wdata;
        io0_valid <= 1'b1;
      end
    end
  end

  // Display stays blank until the first write so a reset never shows stale zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 8; n++) hex_q[n] <= SEG_BLANK;
    end else begin
      for (int n = 0; n < 8; n++)
        hex_q[n] <= io0_valid ? seg7(io0_out[4*n +: 4]) : SEG_BLANK;
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= SW;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic [NUM_SW-1:0] cand;
  logic [DB_W-1:0]   cnt;

  // Whole-vector filter: any new value restarts the hold count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand      <= '0;
      cnt       <= '0;
      sw_stable <= '0;
    end else if (sync2 == sw_stable) begin
      cnt  <= '0;
      cand <= sw_stable;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= DB_W'(1);
    end else if (cnt == CNT_LAST) begin
      sw_stable <= cand;
      cnt       <= '0;
    end else begin
      cnt <= cnt + DB_W'(1);
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sw_stable <= '0;
    else        sw_stable <= sync2;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gpio_rdata <= '0;
    else        gpio_rdata <= 32'(sw_stable);
  end

endmodule
